// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU control codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction function bits onto the
// ALU's operation encoding.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only means sub for R-type; addi reuses that bit as immediate
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath: sequences fetch, decode
// and per-class execute steps, and drives all mux selects and write enables.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic               illegal_instr,
    output logic [STATE_W-1:0] state_dbg
);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] aluop;
    logic       pc_update;
    logic       branch;
    logic       ir_write_raw;
    logic       mem_write_raw;
    logic       reg_write_raw;
    logic       illegal_raw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        aluop         = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;

        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                alu_src_a    = SRCA_PC;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                pc_update    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                // Precompute PC+imm here so BEQ/JAL find the target already in ALUOut
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                result_src = RES_ALUOUT;
                adr_src    = 1'b1;
                state_d    = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_READDATA;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                result_src    = RES_ALUOUT;
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_RD2;
                aluop     = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src    = RES_ALUOUT;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_JAL: begin
                // Link value PC+4 is formed from OldPC while ALUOut steers the PC
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                pc_update  = 1'b1;
                state_d    = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                aluop      = ALUOP_SUB;
                result_src = RES_ALUOUT;
                branch     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i       (aluop),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (alu_control)
    );

    // Architectural side effects are suppressed for the whole reset-low cycle
    assign pc_write      = rst_n & (pc_update | (branch & zero));
    assign ir_write      = rst_n & ir_write_raw;
    assign mem_write     = rst_n & mem_write_raw;
    assign reg_write     = rst_n & reg_write_raw;
    assign illegal_instr = rst_n & illegal_raw;
    assign state_dbg     = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized and directed bench for multicycle_controller, checked every cycle
// against a per-instruction step-list model of the control sequence.
module tb_multicycle_controller;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RT   = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;
    int step  = 0;
    int obs_n = 0;
    logic [3:0] obs_state [0:15];
    logic [4:0] obs_en    [0:15];   // {pc_write, ir_write, mem_write, reg_write, illegal_instr}
    logic [2:0] obs_alu   [0:15];
    logic       obs_adr   [0:15];
    logic [1:0] obs_res   [0:15];

    multicycle_controller #(.STATE_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    // Each instruction class is a fixed list of state numbers, one hex digit per cycle
    function automatic int seq_code(input logic [6:0] o);
        case (o)
            LW:      return 32'h01234;
            SW:      return 32'h0125;
            RT:      return 32'h0167;
            IT:      return 32'h0187;
            JAL:     return 32'h0197;
            BEQ:     return 32'h01A;
            default: return 32'h01;
        endcase
    endfunction

    function automatic int seq_len(input logic [6:0] o);
        case (o)
            LW:                return 5;
            SW, RT, IT, JAL:   return 4;
            BEQ:               return 3;
            default:           return 2;
        endcase
    endfunction

    function automatic int exp_state(input logic [6:0] o, input int s);
        return (seq_code(o) >> (4 * (seq_len(o) - 1 - s))) & 15;
    endfunction

    function automatic logic legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BEQ) || (o == JAL);
    endfunction

    function automatic int funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'd0) return (o == RT && f7) ? 1 : 0;
        if (f3 == 3'd2) return 5;
        if (f3 == 3'd6) return 3;
        if (f3 == 3'd7) return 2;
        return 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input logic r);
        int es;
        int e_alu, e_res, e_sa, e_sb, e_imm;
        @(negedge clk);
        op = o; funct3 = f3; funct7b5 = f7; zero = z; rst_n = r;
        #1;
        es    = exp_state(o, step);
        e_alu = (es == 6 || es == 8) ? funct_alu(o, f3, f7) : (es == 10 ? 1 : 0);
        e_res = (es == 0) ? 2 : (es == 4 ? 1 : 0);
        e_sa  = (es == 1 || es == 9) ? 1 :
                ((es == 2 || es == 6 || es == 8 || es == 10) ? 2 : 0);
        e_sb  = (es == 0 || es == 9) ? 2 : ((es == 1 || es == 2 || es == 8) ? 1 : 0);
        e_imm = (o == SW) ? 1 : (o == BEQ) ? 2 : (o == JAL) ? 3 : 0;
        chk("state",       state_dbg,     es);
        chk("pc_write",    pc_write,      int'(r && (es == 0 || es == 9 || (es == 10 && z))));
        chk("ir_write",    ir_write,      int'(r && es == 0));
        chk("mem_write",   mem_write,     int'(r && es == 5));
        chk("reg_write",   reg_write,     int'(r && (es == 4 || es == 7)));
        chk("illegal",     illegal_instr, int'(r && es == 1 && !legal(o)));
        chk("adr_src",     adr_src,       int'(es == 3 || es == 5));
        chk("result_src",  result_src,    e_res);
        chk("alu_src_a",   alu_src_a,     e_sa);
        chk("alu_src_b",   alu_src_b,     e_sb);
        chk("alu_control", alu_control,   e_alu);
        chk("imm_src",     imm_src,       e_imm);
        if (obs_n < 16) begin
            obs_state[obs_n] = state_dbg;
            obs_en[obs_n]    = {pc_write, ir_write, mem_write, reg_write, illegal_instr};
            obs_alu[obs_n]   = alu_control;
            obs_adr[obs_n]   = adr_src;
            obs_res[obs_n]   = result_src;
            obs_n++;
        end
        @(posedge clk);
        if (!r) begin
            step = 0;
        end else begin
            step++;
            if (step >= seq_len(o)) step = 0;
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z);
        obs_n = 0;
        for (int i = 0; i < seq_len(o); i++) cycle(o, f3, f7, z, 1'b1);
        #1;
        chk("back_to_fetch", state_dbg, 0);
        $display("instr op=%b f3=%b f7=%b z=%b cycles=%0d alu_exec=%b", o, f3, f7, z,
                 seq_len(o), obs_alu[(seq_len(o) > 2) ? 2 : 1]);
    endtask

    initial begin
        logic [6:0] r_op;
        logic [2:0] r_f3;
        logic       r_f7;
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", state_dbg, 0);
        chk("reset_enables", {pc_write, ir_write, mem_write, reg_write, illegal_instr}, 0);

        // lw: five states, single register write with ReadData in the last one
        run_instr(LW, 3'b010, 1'b0, 1'b0);
        chk("lw_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3], obs_state[4]}, 20'h01234);
        chk("lw_regw_mask", {obs_en[4][1], obs_en[3][1], obs_en[2][1], obs_en[1][1], obs_en[0][1]}, 5'b10000);
        chk("lw_wb_result", obs_res[4], 1);

        // sw: write strobe only in MEMWRITE, addressed by Result
        run_instr(SW, 3'b010, 1'b0, 1'b1);
        chk("sw_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3]}, 16'h0125);
        chk("sw_memw_mask", {obs_en[3][2], obs_en[2][2], obs_en[1][2], obs_en[0][2]}, 4'b1000);
        chk("sw_regw_mask", {obs_en[3][1], obs_en[2][1], obs_en[1][1], obs_en[0][1]}, 4'b0000);
        chk("sw_adr", obs_adr[3], 1);

        run_instr(RT, 3'b000, 1'b1, 1'b0);
        chk("r_sub", obs_alu[2], 3'b001);
        run_instr(IT, 3'b000, 1'b1, 1'b0);
        chk("addi", obs_alu[2], 3'b000);
        run_instr(RT, 3'b110, 1'b0, 1'b0);
        chk("r_or", obs_alu[2], 3'b011);
        run_instr(RT, 3'b111, 1'b0, 1'b0);
        chk("r_and", obs_alu[2], 3'b010);
        run_instr(IT, 3'b010, 1'b0, 1'b0);
        chk("slti", obs_alu[2], 3'b101);

        run_instr(BEQ, 3'b000, 1'b0, 1'b1);
        chk("beq_taken_pcw", {obs_en[2][4], obs_en[1][4], obs_en[0][4]}, 3'b101);
        run_instr(BEQ, 3'b000, 1'b0, 1'b0);
        chk("beq_not_taken_pcw", {obs_en[2][4], obs_en[1][4], obs_en[0][4]}, 3'b001);

        run_instr(JAL, 3'b000, 1'b0, 1'b0);
        chk("jal_states", {obs_state[0], obs_state[1], obs_state[2], obs_state[3]}, 16'h0197);

        run_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        chk("illegal_decode_en", obs_en[1], 5'b00001);
        chk("illegal_fetch_flag", obs_en[0][0], 0);

        // Reset asserted during lw's MEMADR cycle
        obs_n = 0;
        cycle(LW, 3'b010, 1'b0, 1'b0, 1'b1);
        cycle(LW, 3'b010, 1'b0, 1'b0, 1'b1);
        cycle(LW, 3'b010, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rst_mid_state", state_dbg, 0);
        chk("rst_mid_enables", obs_en[2], 0);
        chk("rst_mid_seen_memadr", obs_state[2], 2);
        obs_n = 0;
        cycle(LW, 3'b010, 1'b0, 1'b0, 1'b1);
        cycle(LW, 3'b010, 1'b0, 1'b0, 1'b1);
        chk("rst_release_no_wb", obs_en[1][1] | obs_en[0][1], 0);
        $display("instr reset during lw MEMADR, refetched state=%0d", obs_state[0]);
        // finish that lw so the random phase starts at FETCH
        while (step != 0) cycle(LW, 3'b010, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 7))
                0: r_op = LW;
                1: r_op = SW;
                2: r_op = RT;
                3: r_op = IT;
                4: r_op = BEQ;
                5: r_op = JAL;
                default: begin
                    r_op = 7'($urandom);
                    if (legal(r_op)) r_op = 7'b1111111;
                end
            endcase
            r_f3 = 3'($urandom);
            r_f7 = 1'($urandom);
            obs_n = 0;
            do begin
                cycle(r_op, r_f3, r_f7, 1'($urandom), ($urandom_range(0, 24) != 0));
            end while (step != 0);
            $display("instr rnd op=%b f3=%b f7=%b cycles=%0d", r_op, r_f3, r_f7, obs_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
